// File: rtl/gpu_palette_pkg.sv
// Shared types and sizing helpers for the palette memory and its control-port master.
package gpu_palette_pkg;

  localparam int DEFAULT_NUMBER_OF_LAYERS = 32;
  localparam int DEFAULT_PALETTE_SIZE     = 32;

  typedef logic [23:0] rgb24_t;

  // IDLE: take commands | LOAD: write words | READ: fetch words | DRAIN: wait for last word to leave
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } palette_ldr_state_t;

  function automatic int layer_width(input int number_of_layers);
    return (number_of_layers > 1) ? $clog2(number_of_layers) : 1;
  endfunction

  function automatic int palette_width(input int palette_size);
    return (palette_size > 1) ? $clog2(palette_size) : 1;
  endfunction

endpackage

// File: rtl/palette_loader_if.sv
// Command, load-data, readback and palette-memory control signals of the palette loader.
interface palette_loader_if
  import gpu_palette_pkg::*;
#(
  parameter int NUMBER_OF_LAYERS = DEFAULT_NUMBER_OF_LAYERS,
  parameter int PALETTE_SIZE     = DEFAULT_PALETTE_SIZE
);
  localparam int LAYER_WIDTH   = layer_width(NUMBER_OF_LAYERS);
  localparam int PALETTE_WIDTH = palette_width(PALETTE_SIZE);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_read;
  logic [LAYER_WIDTH-1:0]   cmd_layer;
  logic [PALETTE_WIDTH-1:0] cmd_start_idx;
  logic [PALETTE_WIDTH:0]   cmd_count;

  logic                     wr_valid;
  logic                     wr_ready;
  rgb24_t                   wr_data;

  logic                     rd_valid;
  logic                     rd_ready;
  rgb24_t                   rd_data;

  logic                     ctrl_write_en;
  logic                     ctrl_read_en;
  logic [LAYER_WIDTH-1:0]   ctrl_layer;
  logic [PALETTE_WIDTH-1:0] ctrl_palette_idx;
  rgb24_t                   ctrl_data_o;
  rgb24_t                   mem_data_i;

  logic                     busy;
  logic                     done;
  logic                     err;

  modport master (
    input  cmd_valid, cmd_read, cmd_layer, cmd_start_idx, cmd_count,
    input  wr_valid, wr_data, rd_ready, mem_data_i,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output ctrl_write_en, ctrl_read_en, ctrl_layer, ctrl_palette_idx, ctrl_data_o,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_read, cmd_layer, cmd_start_idx, cmd_count,
    output wr_valid, wr_data, rd_ready, mem_data_i,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  ctrl_write_en, ctrl_read_en, ctrl_layer, ctrl_palette_idx, ctrl_data_o,
    input  busy, done, err
  );

endinterface

// File: rtl/palette_rd_stage.sv
// Readback holding register: keeps rd_data stable until the consumer takes it.
module palette_rd_stage
  import gpu_palette_pkg::*;
(
  input  logic   clk_n,
  input  logic   rst,
  input  logic   capture,
  input  rgb24_t capture_data,
  input  logic   rd_ready,
  output logic   rd_valid,
  output rgb24_t rd_data,
  output logic   capture_ok
);

  // A new word may enter when the slot is empty or is being emptied this cycle.
  assign capture_ok = !rd_valid || rd_ready;

  always_ff @(posedge clk_n) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (capture) begin
      rd_valid <= 1'b1;
      rd_data  <= capture_data;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/palette_loader.sv
// Palette memory control-port master: streams load words into one layer or reads entries back.
module palette_loader
  import gpu_palette_pkg::*;
#(
  parameter int NUMBER_OF_LAYERS = DEFAULT_NUMBER_OF_LAYERS,
  parameter int PALETTE_SIZE     = DEFAULT_PALETTE_SIZE
) (
  input logic              clk_n,
  input logic              rst,
  palette_loader_if.master bus
);

  localparam int LAYER_WIDTH   = layer_width(NUMBER_OF_LAYERS);
  localparam int PALETTE_WIDTH = palette_width(PALETTE_SIZE);
  localparam int COUNT_WIDTH   = PALETTE_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(PALETTE_SIZE);
  localparam logic [COUNT_WIDTH-1:0] ONE_LEFT  = COUNT_WIDTH'(1);

  palette_ldr_state_t       state, state_next;
  logic [LAYER_WIDTH-1:0]   layer, layer_next;
  logic [PALETTE_WIDTH-1:0] idx, idx_next;
  logic [PALETTE_WIDTH-1:0] mem_idx, mem_idx_next;
  logic [COUNT_WIDTH-1:0]   remaining, remaining_next;
  logic [COUNT_WIDTH-1:0]   clamped_count;
  rgb24_t                   write_data, write_data_next;
  logic                     write_en, write_en_next;
  logic                     read_en, read_en_next;
  logic                     done, done_next;
  logic                     err, err_next;
  logic                     cmd_ready;
  logic                     wr_ready;
  logic                     capture;
  logic                     capture_ok;
  logic                     last_word;
  logic                     rd_valid;
  rgb24_t                   rd_data;

  always_ff @(posedge clk_n) begin
    if (rst) begin
      state      <= IDLE;
      layer      <= '0;
      idx        <= '0;
      mem_idx    <= '0;
      remaining  <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
      read_en    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      layer      <= layer_next;
      idx        <= idx_next;
      mem_idx    <= mem_idx_next;
      remaining  <= remaining_next;
      write_data <= write_data_next;
      write_en   <= write_en_next;
      read_en    <= read_en_next;
      done       <= done_next;
      err        <= err_next;
    end
  end

  always_comb begin
    state_next      = state;
    layer_next      = layer;
    idx_next        = idx;
    mem_idx_next    = mem_idx;
    remaining_next  = remaining;
    write_data_next = write_data;
    write_en_next   = 1'b0;
    read_en_next    = read_en;
    done_next       = 1'b0;
    err_next        = 1'b0;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    capture         = 1'b0;
    clamped_count   = (bus.cmd_count > MAX_COUNT) ? MAX_COUNT : bus.cmd_count;
    last_word       = (remaining == ONE_LEFT);

    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          // Rejected and empty commands complete without touching the memory.
          if (int'(bus.cmd_layer) >= NUMBER_OF_LAYERS) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else if (bus.cmd_count == '0) begin
            done_next = 1'b1;
          end else begin
            layer_next     = bus.cmd_layer;
            idx_next       = bus.cmd_start_idx;
            remaining_next = clamped_count;
            if (bus.cmd_read) begin
              state_next   = READ;
              read_en_next = 1'b1;
              mem_idx_next = bus.cmd_start_idx;
            end else begin
              state_next = LOAD;
            end
          end
        end
      end

      LOAD: begin
        wr_ready = 1'b1;
        if (bus.wr_valid) begin
          write_en_next   = 1'b1;
          write_data_next = bus.wr_data;
          mem_idx_next    = idx;
          idx_next        = idx + 1'b1;
          remaining_next  = remaining - 1'b1;
          if (last_word) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      READ: begin
        // Address only advances when the holding register can take the current word.
        capture = capture_ok;
        if (capture_ok) begin
          idx_next       = idx + 1'b1;
          mem_idx_next   = idx + 1'b1;
          remaining_next = remaining - 1'b1;
          if (last_word) begin
            state_next   = DRAIN;
            read_en_next = 1'b0;
          end
        end
      end

      DRAIN: begin
        if (rd_valid && bus.rd_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  palette_rd_stage u_rd_stage (
    .clk_n        (clk_n),
    .rst          (rst),
    .capture      (capture),
    .capture_data (bus.mem_data_i),
    .rd_ready     (bus.rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .capture_ok   (capture_ok)
  );

  assign bus.cmd_ready        = cmd_ready;
  assign bus.wr_ready         = wr_ready;
  assign bus.rd_valid         = rd_valid;
  assign bus.rd_data          = rd_data;
  assign bus.ctrl_write_en    = write_en;
  assign bus.ctrl_read_en     = read_en;
  assign bus.ctrl_layer       = layer;
  assign bus.ctrl_palette_idx = mem_idx;
  assign bus.ctrl_data_o      = write_data;
  assign bus.busy             = (state != IDLE);
  assign bus.done             = done;
  assign bus.err              = err;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader with a behavioural palette memory on the control port.
module tb_palette_loader;
  import gpu_palette_pkg::*;

  // 24 layers keeps the 5-bit layer field while leaving room for out-of-range layers.
  localparam int NL = 24;
  localparam int PS = 32;

  typedef struct packed {
    logic [4:0] layer;
    logic [4:0] idx;
    rgb24_t     data;
    logic       done;
  } wr_rec_t;

  typedef struct {
    logic       rd;
    logic [4:0] layer;
    logic [4:0] start;
    logic [5:0] count;
    logic       exp_err;
  } deg_vec_t;

  logic clk_n = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_n = ~clk_n;

  palette_loader_if #(.NUMBER_OF_LAYERS(NL), .PALETTE_SIZE(PS)) bus ();

  palette_loader #(.NUMBER_OF_LAYERS(NL), .PALETTE_SIZE(PS)) dut (
    .clk_n (clk_n),
    .rst   (rst),
    .bus   (bus)
  );

  rgb24_t mem [32][PS];
  assign bus.mem_data_i = mem[bus.ctrl_layer][bus.ctrl_palette_idx];
  always @(posedge clk_n) if (bus.ctrl_write_en) mem[bus.ctrl_layer][bus.ctrl_palette_idx] = bus.ctrl_data_o;

  int passed = 0;
  int total  = 0;

  wr_rec_t wlog[$];
  rgb24_t  rlog[$];
  int done_cnt = 0, rd_en_cycles = 0, busy_cycles = 0, unstable = 0;
  int overlap = 0, long_done = 0, rd_outside = 0;
  logic   prev_done = 1'b0, stalled = 1'b0;
  rgb24_t held = '0;

  always @(negedge clk_n) begin
    wr_rec_t r;
    if (bus.ctrl_write_en && bus.ctrl_read_en) overlap++;
    if (bus.ctrl_write_en) begin
      r.layer = bus.ctrl_layer;
      r.idx   = bus.ctrl_palette_idx;
      r.data  = bus.ctrl_data_o;
      r.done  = bus.done;
      wlog.push_back(r);
    end
    if (bus.ctrl_read_en) rd_en_cycles++;
    if (bus.busy) busy_cycles++;
    if (bus.done) done_cnt++;
    if (bus.done && prev_done) long_done++;
    prev_done = bus.done;
    if (stalled && bus.rd_valid && bus.rd_data !== held) unstable++;
    if (bus.rd_valid && bus.rd_ready) rlog.push_back(bus.rd_data);
    if (bus.rd_valid && !bus.busy) rd_outside++;
    stalled = bus.rd_valid && !bus.rd_ready;
    held    = bus.rd_data;
  end

  task automatic tick();
    @(posedge clk_n);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    wlog.delete();
    rlog.delete();
    done_cnt = 0; rd_en_cycles = 0; busy_cycles = 0; unstable = 0;
  endtask

  task automatic send_cmd(input logic rd, input logic [4:0] layer, input logic [4:0] start,
                          input logic [5:0] count);
    logic acc;
    acc = 1'b0;
    bus.cmd_read = rd; bus.cmd_layer = layer; bus.cmd_start_idx = start; bus.cmd_count = count;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("cmd_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic load_stream(input int n, input rgb24_t first, input rgb24_t step);
    int   k;
    logic rdy;
    k = 0;
    for (int i = 0; i < 200 && k < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = first + rgb24_t'(k) * step;
      rdy = bus.wr_ready;
      tick();
      if (rdy) k++;
    end
    bus.wr_valid = 1'b0;
    if (k < n) check("load_stream_timeout", 64'(k), 64'(n));
  endtask

  task automatic read_stream(input logic [3:0] pattern, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      bus.rd_ready = pattern[c % 4];
      tick();
      seen = bus.done;
    end
    bus.rd_ready = 1'b0;
    if (!seen) check("read_done_timeout", 64'(seen), 64'(1));
  endtask

  task automatic cmp_wlog(input string name, input int k, input wr_rec_t e);
    if (k >= wlog.size()) check(name, 64'(wlog.size()), 64'(k + 1));
    else check(name, 64'(wlog[k]), 64'(e));
  endtask

  task automatic cmp_rlog(input string name, input int k, input rgb24_t e);
    if (k >= rlog.size()) check(name, 64'(rlog.size()), 64'(k + 1));
    else check(name, 64'(rlog[k]), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    deg_vec_t dv [5];
    wr_rec_t  e;

    for (int l = 0; l < 32; l++) for (int p = 0; p < PS; p++) mem[l][p] = '0;
    bus.cmd_valid = 0; bus.cmd_read = 0; bus.cmd_layer = '0; bus.cmd_start_idx = '0;
    bus.cmd_count = '0; bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("reset_strobes", 64'({bus.wr_ready, bus.rd_valid, bus.ctrl_write_en, bus.ctrl_read_en,
                                bus.busy, bus.done, bus.err}), 64'(0));
    check("reset_addr", 64'({bus.ctrl_layer, bus.ctrl_palette_idx}), 64'(0));
    check("reset_data", 64'({bus.rd_data, bus.ctrl_data_o}), 64'(0));
    rst = 1'b0;
    tick();

    // Commands that complete without memory access
    dv[0] = '{1'b0, 5'd3,  5'd0,  6'd0,  1'b0};
    dv[1] = '{1'b1, 5'd5,  5'd7,  6'd0,  1'b0};
    dv[2] = '{1'b0, 5'd28, 5'd0,  6'd4,  1'b1};
    dv[3] = '{1'b1, 5'd24, 5'd10, 6'd32, 1'b1};
    dv[4] = '{1'b0, 5'd31, 5'd2,  6'd1,  1'b1};
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      send_cmd(dv[i].rd, dv[i].layer, dv[i].start, dv[i].count);
      check($sformatf("deg%0d_done", i), 64'(bus.done), 64'(1));
      check($sformatf("deg%0d_err", i), 64'(bus.err), 64'(dv[i].exp_err));
      tick();
      check($sformatf("deg%0d_pulse_end", i), 64'({bus.done, bus.err}), 64'(0));
    end
    check("deg_no_writes", 64'(wlog.size()), 64'(0));
    check("deg_no_reads", 64'(rd_en_cycles), 64'(0));
    check("deg_never_busy", 64'(busy_cycles), 64'(0));

    // Load layer 3, entries 30,31,0,1
    clear_mon();
    send_cmd(1'b0, 5'd3, 5'd30, 6'd4);
    load_stream(4, 24'h111111, 24'h111111);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      e.layer = 5'd3;
      e.idx   = 5'(30 + k);
      e.data  = rgb24_t'((k + 1) * 24'h111111);
      e.done  = (k == 3);
      cmp_wlog($sformatf("load_wr%0d", k), k, e);
    end
    check("load_write_count", 64'(wlog.size()), 64'(4));
    check("load_done_count", 64'(done_cnt), 64'(1));
    check("load_idle_after", 64'(bus.busy), 64'(0));

    // Readback of the same range, rd_ready 1,0,0,1 repeating
    clear_mon();
    send_cmd(1'b1, 5'd3, 5'd30, 6'd4);
    check("rb_read_en_first", 64'({bus.ctrl_read_en, bus.rd_valid}), 64'(2'b10));
    bus.rd_ready = 1'b1;
    tick();
    check("rb_first_valid", 64'({bus.rd_valid, bus.rd_data}), 64'({1'b1, 24'h111111}));
    read_stream(4'b1100, 40);
    tick();
    for (int k = 0; k < 4; k++)
      cmp_rlog($sformatf("rb_word%0d", k), k, rgb24_t'((k + 1) * 24'h111111));
    check("rb_word_count", 64'(rlog.size()), 64'(4));
    check("rb_stall_stable", 64'(unstable), 64'(0));
    check("rb_read_en_cycles", 64'(rd_en_cycles), 64'(8));
    check("rb_done_count", 64'(done_cnt), 64'(1));
    check("rb_rd_valid_clear", 64'(bus.rd_valid), 64'(0));

    // Count 63 clamps to one full layer; index wraps back to the start
    clear_mon();
    send_cmd(1'b0, 5'd7, 5'd5, 6'd63);
    load_stream(32, 24'h010101, 24'h000001);
    check("wrap_ready_dropped", 64'(bus.wr_ready), 64'(0));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 24'hDEAD00;
    tick();
    tick();
    bus.wr_valid = 1'b0;
    check("wrap_write_count", 64'(wlog.size()), 64'(32));
    e = '{5'd7, 5'd5, 24'h010101, 1'b0};  cmp_wlog("wrap_first", 0, e);
    e = '{5'd7, 5'd31, 24'h01011B, 1'b0}; cmp_wlog("wrap_idx31", 26, e);
    e = '{5'd7, 5'd0, 24'h01011C, 1'b0};  cmp_wlog("wrap_idx0", 27, e);
    e = '{5'd7, 5'd4, 24'h010120, 1'b1};  cmp_wlog("wrap_last", 31, e);
    check("wrap_done_count", 64'(done_cnt), 64'(1));

    // Reset in the middle of an 8-word load
    clear_mon();
    send_cmd(1'b0, 5'd9, 5'd0, 6'd8);
    load_stream(2, 24'hA0A0A0, 24'h000001);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 24'hA0A0A2;
    rst = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rst_strobes", 64'({bus.wr_ready, bus.rd_valid, bus.ctrl_write_en, bus.ctrl_read_en,
                              bus.busy, bus.done, bus.err}), 64'(0));
    check("rst_addr_data", 64'({bus.ctrl_layer, bus.ctrl_palette_idx, bus.ctrl_data_o}), 64'(0));
    rst = 1'b0;
    tick();
    check("rst_entry0_kept", 64'(mem[9][0]), 64'(24'hA0A0A0));
    check("rst_entry1_kept", 64'(mem[9][1]), 64'(24'hA0A0A1));
    check("rst_entry2_dropped", 64'(mem[9][2]), 64'(0));
    check("rst_no_done", 64'(done_cnt), 64'(0));
    send_cmd(1'b0, 5'd9, 5'd4, 6'd2);
    load_stream(2, 24'h0B0B0B, 24'h000001);
    tick();
    e = '{5'd9, 5'd5, 24'h0B0B0C, 1'b1};
    cmp_wlog("post_rst_last", 3, e);
    check("post_rst_done_count", 64'(done_cnt), 64'(1));

    // Back-to-back load then readback with cmd_valid held
    clear_mon();
    bus.cmd_read = 1'b0; bus.cmd_layer = 5'd12; bus.cmd_start_idx = 5'd0; bus.cmd_count = 6'd2;
    bus.cmd_valid = 1'b1;
    tick();
    check("b2b_load_busy", 64'({bus.busy, bus.cmd_ready}), 64'(2'b10));
    bus.cmd_read = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 24'h123456;
    tick();
    bus.wr_data  = 24'h654321;
    tick();
    check("b2b_done_cycle", 64'({bus.done, bus.cmd_ready, bus.ctrl_write_en}), 64'(3'b111));
    bus.wr_valid = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_read_accepted", 64'({bus.ctrl_read_en, bus.ctrl_write_en, bus.done, bus.busy}),
          64'(4'b1001));
    read_stream(4'b1111, 20);
    tick();
    cmp_rlog("b2b_word0", 0, 24'h123456);
    cmp_rlog("b2b_word1", 1, 24'h654321);
    check("b2b_done_count", 64'(done_cnt), 64'(2));

    check("strobe_overlap", 64'(overlap), 64'(0));
    check("done_width", 64'(long_done), 64'(0));
    check("rd_valid_outside", 64'(rd_outside), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
